// File: rtl/pixel_sep_stream.sv
// pixel_sep_stream: 3-stage streaming 2x2 signed fixed-point separator.
// z1 = W11*a + W12*b, z2 = W21*a + W22*b, rounded half up, Q(FRAC_W) coefficients.
// Coefficient updates are staged in a shadow set and copied to the active
// set only at a frame boundary with the pipeline empty.
// Build option: define SEP_SAT_EN to clamp results to [0, 2^PIX_W-1];
// without it the low PIX_W bits of the rounded result are output (wrap).
module pixel_sep_stream #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned COEF_W = 10,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned NPIX   = 65536
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coef_wr,
  input  logic [1:0]                 coef_sel,
  input  logic [COEF_W-1:0]          coef_data,
  input  logic                       coef_commit,
  output logic                       commit_pend,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           in_a,
  input  logic [PIX_W-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PIX_W-1:0]           out_z1,
  output logic [PIX_W-1:0]           out_z2,
  output logic                       out_last,
  output logic [$clog2(NPIX)-1:0]    pix_idx
);

  localparam int unsigned IDX_W  = $clog2(NPIX);
  localparam int unsigned PROD_W = PIX_W + 1 + COEF_W;
  localparam int unsigned SUM_W  = PIX_W + COEF_W + 2;

  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NPIX - 1);
  localparam logic signed [COEF_W-1:0] C_ONE   = COEF_W'(2**FRAC_W);
  localparam logic signed [SUM_W-1:0]  RND     = SUM_W'(2**(FRAC_W - 1));

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  coef_t shadow_q [4];
  coef_t shadow_d [4];
  coef_t active_q [4];

  logic [IDX_W-1:0] pix_idx_q;
  logic             commit_pend_q;

  logic             s1_v_q, s1_last_q;
  logic [PIX_W-1:0] s1_a_q, s1_b_q;

  logic             s2_v_q, s2_last_q;
  prod_t            s2_p_q [4];
  prod_t            prod_d [4];

  logic             out_valid_q, out_last_q;
  logic [PIX_W-1:0] out_z1_q, out_z2_q;
  logic [PIX_W-1:0] z1_d, z2_d;

  logic advance_c, idx_zero_c, in_hs_c, empty_c, copy_c;

  assign advance_c  = !out_valid_q | out_ready;
  assign idx_zero_c = (pix_idx_q == '0);
  assign in_ready   = advance_c & !(commit_pend_q & idx_zero_c);
  assign in_hs_c    = in_valid & in_ready;
  assign empty_c    = !s1_v_q & !s2_v_q & !out_valid_q;
  assign copy_c     = commit_pend_q & idx_zero_c & empty_c;

  assign commit_pend = commit_pend_q;
  assign pix_idx     = pix_idx_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_z1      = out_z1_q;
  assign out_z2      = out_z2_q;

  // Shadow set with this cycle's write folded in, so a same-cycle copy sees it.
  always_comb begin
    for (int i = 0; i < 4; i++) shadow_d[i] = shadow_q[i];
    if (coef_wr) shadow_d[coef_sel] = coef_data;
  end

  // Pixel index, pending-commit flag, shadow and active coefficient sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_idx_q     <= '0;
      commit_pend_q <= 1'b0;
      shadow_q[0]   <= C_ONE;
      shadow_q[1]   <= '0;
      shadow_q[2]   <= '0;
      shadow_q[3]   <= C_ONE;
      active_q[0]   <= C_ONE;
      active_q[1]   <= '0;
      active_q[2]   <= '0;
      active_q[3]   <= C_ONE;
    end else begin
      if (in_hs_c) pix_idx_q <= (pix_idx_q == IDX_LAST) ? '0 : pix_idx_q + IDX_W'(1);
      commit_pend_q <= (commit_pend_q & !copy_c) | coef_commit;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (copy_c) active_q[i] <= shadow_d[i];
      end
    end
  end

  // S1: capture the accepted pair and its end-of-frame flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
    end else if (advance_c) begin
      s1_v_q    <= in_hs_c;
      s1_last_q <= in_hs_c & (pix_idx_q == IDX_LAST);
      s1_a_q    <= in_a;
      s1_b_q    <= in_b;
    end
  end

  logic signed [PIX_W:0] a_ext, b_ext;
  assign a_ext = signed'({1'b0, s1_a_q});
  assign b_ext = signed'({1'b0, s1_b_q});

  // Four signed products against the active coefficient set.
  always_comb begin
    prod_d[0] = PROD_W'(a_ext) * PROD_W'(active_q[0]);
    prod_d[1] = PROD_W'(b_ext) * PROD_W'(active_q[1]);
    prod_d[2] = PROD_W'(a_ext) * PROD_W'(active_q[2]);
    prod_d[3] = PROD_W'(b_ext) * PROD_W'(active_q[3]);
  end

  // S2: register products.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      for (int i = 0; i < 4; i++) s2_p_q[i] <= '0;
    end else if (advance_c) begin
      s2_v_q    <= s1_v_q;
      s2_last_q <= s1_last_q;
      for (int i = 0; i < 4; i++) s2_p_q[i] <= prod_d[i];
    end
  end

  logic signed [SUM_W-1:0] sum1_c, sum2_c, sh1_c, sh2_c;
  assign sum1_c = SUM_W'(s2_p_q[0]) + SUM_W'(s2_p_q[1]) + RND;
  assign sum2_c = SUM_W'(s2_p_q[2]) + SUM_W'(s2_p_q[3]) + RND;
  assign sh1_c  = sum1_c >>> FRAC_W;
  assign sh2_c  = sum2_c >>> FRAC_W;

`ifdef SEP_SAT_EN
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'(2**PIX_W - 1);

  function automatic logic [PIX_W-1:0] clip(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])      return '0;
    else if (v > PIX_MAX) return '1;
    else                 return v[PIX_W-1:0];
  endfunction

  // Clamp rounded sums into the pixel range.
  always_comb begin
    z1_d = clip(sh1_c);
    z2_d = clip(sh2_c);
  end
`else
  logic unused_wrap_bits;
  assign unused_wrap_bits = ^{sh1_c[SUM_W-1:PIX_W], sh2_c[SUM_W-1:PIX_W]};

  // Keep the low pixel bits of the rounded sums.
  always_comb begin
    z1_d = sh1_c[PIX_W-1:0];
    z2_d = sh2_c[PIX_W-1:0];
  end
`endif

  // S3: output register, held while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_z1_q    <= '0;
      out_z2_q    <= '0;
    end else if (advance_c) begin
      out_valid_q <= s2_v_q;
      out_last_q  <= s2_last_q;
      out_z1_q    <= z1_d;
      out_z2_q    <= z2_d;
    end
  end

endmodule

// File: tb/tb_pixel_sep_stream.sv
// Self-checking bench for pixel_sep_stream (NPIX=4), with a frame-level
// reference model that applies a commit at the next frame's first pixel.
module tb_pixel_sep_stream;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned COEF_W = 10;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned NPIX   = 4;

`ifdef SEP_SAT_EN
  localparam int EXP_Z2  = 0;
  localparam int EXP_OVF = 255;
`else
  localparam int EXP_Z2  = 206;
  localparam int EXP_OVF = 44;
`endif

  logic clk = 1'b0;
  logic rst, coef_wr, coef_commit, in_valid, out_ready;
  logic [1:0] coef_sel;
  logic [COEF_W-1:0] coef_data;
  logic [PIX_W-1:0] in_a, in_b;
  logic commit_pend, in_ready, out_valid, out_last;
  logic [PIX_W-1:0] out_z1, out_z2;
  logic [1:0] pix_idx;

  pixel_sep_stream #(.PIX_W(PIX_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .NPIX(NPIX)) dut (
    .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_sel(coef_sel), .coef_data(coef_data),
    .coef_commit(coef_commit), .commit_pend(commit_pend), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_z1(out_z1), .out_z2(out_z2), .out_last(out_last),
    .pix_idx(pix_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] z1;
    logic [7:0] z2;
    logic       last;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   sh[4] = '{256, 0, 0, 256};
  int   ac[4] = '{256, 0, 0, 256};
  bit   m_pend = 0;
  int   m_idx = 0;
  bit   held = 0;
  logic [7:0] h_z1, h_z2;
  logic h_last;
  int   out_count = 0;
  int   lastpos[$];
  bit   done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference separation: integer mix, round half up, then clamp or wrap.
  function automatic logic [7:0] mix(input int a, input int b, input int wa, input int wb);
    int s;
    s = a * wa + b * wb + 128;
    s = s >>> 8;
`ifdef SEP_SAT_EN
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
`endif
    return 8'(s);
  endfunction

  // Scoreboard and model, evaluated mid-cycle on what the next edge will do.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_idx = 0;
      m_pend = 0;
      held = 0;
      sh = '{256, 0, 0, 256};
      ac = '{256, 0, 0, 256};
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_z1", out_z1, h_z1);
        chk("hold_z2", out_z2, h_z2);
        chk("hold_last", out_last, h_last);
      end
      held = out_valid && !out_ready;
      h_z1 = out_z1; h_z2 = out_z2; h_last = out_last;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("z1", out_z1, e.z1);
          chk("z2", out_z2, e.z2);
          chk("last", out_last, e.last);
          if (out_last) lastpos.push_back(out_count);
          out_count++;
        end
      end
      chk("pix_idx", pix_idx, m_idx);
      if (in_valid && in_ready) begin
        if (m_idx == 0 && m_pend) begin
          ac = sh;
          m_pend = 0;
        end
        e.z1 = mix(in_a, in_b, ac[0], ac[1]);
        e.z2 = mix(in_a, in_b, ac[2], ac[3]);
        e.last = (m_idx == NPIX - 1);
        q.push_back(e);
        m_idx = (m_idx + 1) % NPIX;
      end
      if (coef_wr) sh[coef_sel] = int'($signed(coef_data));
      if (coef_commit) m_pend = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic wr(input int sel, input int v);
    coef_wr = 1'b1; coef_sel = 2'(sel); coef_data = COEF_W'(v);
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    @(posedge clk); #1;
    coef_commit = 1'b0;
  endtask

  // Leaves the caller at a negedge with out_valid high (or a timeout recorded).
  task automatic wait_out(input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    chk({tag, "_timeout"}, out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && n < 100) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; coef_wr = 1'b0; coef_commit = 1'b0; coef_sel = '0; coef_data = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_z1", out_z1, 0);
    chk("rst_z2", out_z2, 0);
    chk("rst_pix_idx", pix_idx, 0);
    chk("rst_commit_pend", commit_pend, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Identity and three-cycle latency.
    push(8'd37, 8'd200);
    @(negedge clk); chk("lat_c1", out_valid, 0);
    @(negedge clk); chk("lat_c2", out_valid, 0);
    @(negedge clk); chk("lat_c3", out_valid, 1);
    chk("ident_z1", out_z1, 37);
    chk("ident_z2", out_z2, 200);
    @(posedge clk); #1;
    fill(3);

    // Averaging row.
    wr(0, 128); wr(1, 128); commit();
    push(8'd100, 8'd50);
    wait_out("mix"); chk("mix_z1", out_z1, 75);
    @(posedge clk); #1;
    fill(3);

    // Difference row producing a negative result.
    wr(2, 256); wr(3, -256); commit();
    push(8'd50, 8'd100);
    wait_out("neg"); chk("neg_z2", out_z2, EXP_Z2);
    @(posedge clk); #1;
    fill(3);

    // Sum above full scale.
    wr(0, 256); wr(1, 256); commit();
    push(8'd200, 8'd100);
    wait_out("ovf"); chk("ovf_z1", out_z1, EXP_OVF);
    @(posedge clk); #1;
    fill(3);

    // Five-cycle sink stall in a continuous stream.
    fork
      fill(12);
      begin
        idle(4);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_out_valid", out_valid, 1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join

    // Random coefficient sets with random gaps and random backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 4; s++) wr(s, int'($urandom_range(0, 1023)));
      commit();
      done = 0;
      fork
        begin
          for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 2)));
            push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          end
          done = 1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      out_ready = 1'b1;
    end

    // Commit raised mid-frame is deferred to the next frame.
    wr(0, 200); wr(1, -50); wr(2, 30); wr(3, 300);
    fill(2);
    commit();
    @(negedge clk);
    chk("dc_pend_set", commit_pend, 1);
    chk("dc_idx2", pix_idx, 2);
    @(posedge clk); #1;
    fill(2);
    begin
      int n = 0;
      @(negedge clk);
      chk("dc_idx0", pix_idx, 0);
      while (commit_pend && n < 50) begin
        chk("dc_in_ready", in_ready, 0);
        @(negedge clk);
        n++;
      end
      chk("dc_pend_clear", commit_pend, 0);
      chk("dc_empty", out_valid, 0);
      chk("dc_ready_back", in_ready, 1);
    end
    @(posedge clk); #1;
    fill(4);
    drain();
    @(posedge clk); #1;

    // Frame marking over 10 pairs from reset.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    out_count = 0;
    lastpos.delete();
    fill(10);
    drain();
    chk("frame_idx", pix_idx, 2);
    chk("frame_nlast", lastpos.size(), 2);
    chk("frame_last0", (lastpos.size() > 0) ? lastpos[0] : -1, 3);
    chk("frame_last1", (lastpos.size() > 1) ? lastpos[1] : -1, 7);
    @(posedge clk); #1;

    // Reset with two pairs in flight and a pending commit.
    wr(0, 300); commit();
    @(negedge clk);
    chk("rp_pend_set", commit_pend, 1);
    @(posedge clk); #1;
    fill(2);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rp_no_out", out_valid, 0);
    end
    chk("rp_pend_clear", commit_pend, 0);
    chk("rp_idx", pix_idx, 0);
    @(posedge clk); #1;
    push(8'd37, 8'd200);
    wait_out("rp_ident");
    chk("rp_z1", out_z1, 37);
    chk("rp_z2", out_z2, 200);
    @(posedge clk); #1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
